// File: rtl/joy_sega_reader.sv
// Scans two DB9 ports through the shared select line and decodes Atari, Sega 3- and 6-button pads.
// Outputs are active-low MXYZ SACB RLDU words committed atomically once per scan.
module joy_sega_reader #(
  parameter int TICK_DIV   = 256,
  parameter int IDLE_STEPS = 192
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic [5:0]  joy1_i,
  input  logic [5:0]  joy2_i,
  output logic        joy_p7_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six_btn1_o,
  output logic        six_btn2_o,
  output logic        scan_done_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (IDLE_STEPS > 1) ? $clog2(IDLE_STEPS) : 1;

  typedef enum logic [3:0] {S0, S1, S2, S3, S4, S5, S6, S7, IDLE} state_t;

  state_t        state;
  logic [5:0]    j1_meta, j1_sync, j2_meta, j2_sync;
  logic [1:0]    prime;
  logic [TW-1:0] tick;
  logic [IW-1:0] idle_cnt;
  logic [11:0]   sh1, sh2;
  logic          six1, six2;
  logic          step_end;
  logic [12:0]   nxt1, nxt2;

  // Per-port decode of one step's sample; returns {six, shadow}.
  function automatic logic [12:0] sample(input state_t st, input logic [5:0] p,
                                         input logic [11:0] sh, input logic six);
    logic [11:0] s;
    logic        f;
    s = sh;
    f = six;
    case (st)
      S3:      s[5:0]  = p;
      S4:      s[7:6]  = (p[3:2] == 2'b00) ? p[5:4] : 2'b11;
      S6:      f       = (p[3:0] == 4'h0);
      S7:      s[11:8] = six ? p[3:0] : 4'hF;
      default: s       = sh;
    endcase
    return {f, s};
  endfunction

  // The tick counter waits until the synchronisers hold real pin values.
  assign step_end = prime[1] && (tick == TW'(TICK_DIV - 1));
  assign nxt1     = sample(state, j1_sync, sh1, six1);
  assign nxt2     = sample(state, j2_sync, sh2, six2);

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      j1_meta     <= 6'h3F;
      j1_sync     <= 6'h3F;
      j2_meta     <= 6'h3F;
      j2_sync     <= 6'h3F;
      prime       <= 2'd0;
      tick        <= '0;
      idle_cnt    <= '0;
      state       <= S0;
      sh1         <= 12'hFFF;
      sh2         <= 12'hFFF;
      six1        <= 1'b0;
      six2        <= 1'b0;
      joy_p7_o    <= 1'b1;
      joy1_o      <= 12'hFFF;
      joy2_o      <= 12'hFFF;
      six_btn1_o  <= 1'b0;
      six_btn2_o  <= 1'b0;
      scan_done_o <= 1'b0;
    end else begin
      j1_meta     <= joy1_i;
      j1_sync     <= j1_meta;
      j2_meta     <= joy2_i;
      j2_sync     <= j2_meta;
      scan_done_o <= 1'b0;
      joy_p7_o    <= !(state == S0 || state == S2 || state == S4 || state == S6);
      if (!prime[1])
        prime <= prime + 2'd1;
      if (prime[1])
        tick <= step_end ? '0 : tick + TW'(1);

      if (step_end) begin
        {six1, sh1} <= nxt1;
        {six2, sh2} <= nxt2;
        case (state)
          S7: begin
            state       <= IDLE;
            idle_cnt    <= '0;
            joy1_o      <= nxt1[11:0];
            joy2_o      <= nxt2[11:0];
            six_btn1_o  <= nxt1[12];
            six_btn2_o  <= nxt2[12];
            scan_done_o <= 1'b1;
          end
          IDLE: begin
            if (idle_cnt == IW'(IDLE_STEPS - 1))
              state <= S0;
            else
              idle_cnt <= idle_cnt + IW'(1);
          end
          default: state <= state_t'(state + 4'd1);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_joy_sega_reader.sv
// Drives behavioural Atari / 3-button / 6-button pad models on both ports and checks every
// cycle's outputs against the word each scan must commit, plus latency and period.
module tb_joy_sega_reader;

  localparam int TD  = 4;
  localparam int IS  = 4;
  localparam int PER = (8 + IS) * TD;

  logic        clk = 1'b0;
  logic        res_n;
  logic [5:0]  joy1_i, joy2_i;
  logic        p7;
  logic [11:0] joy1_o, joy2_o;
  logic        six1, six2, scan_done;

  int checks = 0;
  int errors = 0;

  // Pad configuration: type 0 none, 1 Atari, 2 3-button, 3 6-button.
  // Button vector (active high): 0 U,1 D,2 L,3 R,4 B,5 C,6 A,7 Start,8 Z,9 Y,10 X,11 Mode.
  int          t1 = 0, t2 = 0;
  logic [11:0] b1 = '0, b2 = '0;
  int          nf = 0;
  int          hi_cnt = 0;

  joy_sega_reader #(.TICK_DIV(TD), .IDLE_STEPS(IS)) dut (
    .clk_i(clk), .res_n_i(res_n), .joy1_i(joy1_i), .joy2_i(joy2_i),
    .joy_p7_o(p7), .joy1_o(joy1_o), .joy2_o(joy2_o),
    .six_btn1_o(six1), .six_btn2_o(six2), .scan_done_o(scan_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pin levels {p9,p6,right,left,down,up} a pad presents for a given select level.
  function automatic logic [5:0] pad_pins(input int t, input logic [11:0] b,
                                          input logic sel, input int n);
    logic six_ph;
    six_ph = (t == 3) && (n == 4);
    case (t)
      1: return ~b[5:0];
      2, 3: begin
        if (sel)
          return six_ph ? ~{b[5], b[4], b[11], b[10], b[9], b[8]} : ~b[5:0];
        else
          return six_ph ? {~b[7], ~b[6], 4'b0000} : {~b[7], ~b[6], 2'b00, ~b[1], ~b[0]};
      end
      default: return 6'h3F;
    endcase
  endfunction

  // Word and six flag a complete scan of a given pad must yield.
  function automatic logic [12:0] model(input int t, input logic [11:0] b);
    case (t)
      1:       return {1'b0, 6'h3F, ~b[5:0]};
      2:       return {1'b0, 4'hF, ~b[7:0]};
      3:       return {1'b1, ~b};
      default: return {1'b0, 12'hFFF};
    endcase
  endfunction

  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[0] && b[1]) b[1] = 1'b0;
    if (b[2] && b[3]) b[3] = 1'b0;
    return b;
  endfunction

  // The 6-button pad counts select falling edges and forgets them after a long high period.
  always @(posedge clk) hi_cnt <= p7 ? hi_cnt + 1 : 0;
  always @(negedge p7)  nf <= (hi_cnt > 10) ? 1 : nf + 1;

  always @* begin
    joy1_i = pad_pins(t1, b1, p7, nf);
    joy2_i = pad_pins(t2, b2, p7, nf);
  end

  // Compare process: outputs hold the last committed word; each commit shows the word
  // of the configuration held through that scan (captured early in the idle gap).
  logic [11:0] cur1 = 12'hFFF, cur2 = 12'hFFF;
  logic        cs1 = 1'b0, cs2 = 1'b0;
  logic [12:0] pend1, pend2;
  int          snap = 99;

  always @(negedge clk) begin
    if (!res_n) begin
      cur1 = 12'hFFF; cur2 = 12'hFFF; cs1 = 1'b0; cs2 = 1'b0;
      pend1 = model(t1, b1);
      pend2 = model(t2, b2);
      snap = 99;
    end else begin
      if (scan_done) begin
        {cs1, cur1} = pend1;
        {cs2, cur2} = pend2;
        snap = 0;
      end else if (snap < 99) begin
        snap++;
      end
      if (snap == 8) begin
        pend1 = model(t1, b1);
        pend2 = model(t2, b2);
      end
      chk("joy1_o", joy1_o, cur1);
      chk("joy2_o", joy2_o, cur2);
      chk("six_btn1_o", six1, cs1);
      chk("six_btn2_o", six2, cs2);
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < 400);
    if (!scan_done) begin
      errors++;
      $display("FAIL scan_done_timeout actual=none required=pulse within 400 cycles");
    end
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  int n;

  initial begin
    res_n = 1'b0;
    wait_neg(5);
    chk("rst_joy1", joy1_o, 12'hFFF);
    chk("rst_joy2", joy2_o, 12'hFFF);
    chk("rst_six1", six1, 0);
    chk("rst_six2", six2, 0);
    chk("rst_p7", p7, 1);
    chk("rst_done", scan_done, 0);
    res_n = 1'b1;
    wait_done(n);
    chk("first_commit_latency", n, 8 * TD + 2);
    chk("idle_word1", joy1_o, 12'hFFF);
    wait_done(n);
    chk("scan_period", n, PER);

    // Atari on port 1: Up + fire(p6).
    @(posedge clk); t1 = 1; b1 = 12'h011;
    wait_done(n);
    chk("period_atari", n, PER);
    chk("atari_joy1", joy1_o, 12'hFEE);
    chk("atari_six1", six1, 0);
    chk("atari_joy2", joy2_o, 12'hFFF);

    // 3-button on port 2: A + Start + Right.
    @(posedge clk); t2 = 2; b2 = 12'h0C8;
    wait_done(n);
    chk("3btn_joy2", joy2_o, 12'hF37);
    chk("3btn_six2", six2, 0);

    // 6-button on port 1: X + C.
    @(posedge clk); t1 = 3; b1 = 12'h420;
    wait_done(n);
    chk("6btn_joy1", joy1_o, 12'hBDF);
    chk("6btn_six1", six1, 1);
    chk("6btn_joy2_indep", joy2_o, 12'hF37);

    // Change port 2 buttons during S5: this scan keeps the old word, the next shows the new.
    wait_neg(38);
    b2 = 12'h011;
    wait_done(n);
    chk("midscan_old_joy2", joy2_o, 12'hF37);
    wait_done(n);
    chk("midscan_new_joy2", joy2_o, 12'hFEE);

    // Reset during S4, then the scan restarts from S0.
    wait_neg(33);
    res_n = 1'b0;
    #1;
    chk("midrst_joy1", joy1_o, 12'hFFF);
    chk("midrst_joy2", joy2_o, 12'hFFF);
    chk("midrst_six1", six1, 0);
    chk("midrst_p7", p7, 1);
    @(negedge clk);
    wait_neg(20);
    res_n = 1'b1;
    wait_done(n);
    chk("restart_latency", n, 8 * TD + 2);
    chk("restart_joy1", joy1_o, 12'hBDF);
    chk("restart_six1", six1, 1);

    // Randomised pads and buttons, one new configuration per scan.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      t1 = $urandom_range(0, 3); b1 = rand_btn();
      t2 = $urandom_range(0, 3); b2 = rand_btn();
      wait_done(n);
      chk("rand_period", n, PER);
    end
    wait_done(n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
